// File: rtl/sm_fetch_pair.sv
// Dual-issue fetch stage: reads two consecutive ROM words per cycle into a
// 4-entry in-order queue and presents the two oldest entries downstream.
module sm_fetch_pair #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 64,
  parameter int          AW        = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imAddr,
  input  logic [31:0] imData1,
  input  logic [31:0] imData2,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  take,
  output logic        i0_valid,
  output logic [31:0] i0_instr,
  output logic [31:0] i0_pc,
  output logic        i1_valid,
  output logic [31:0] i1_instr,
  output logic [31:0] i1_pc
);

  localparam logic [AW-1:0] LAST_WORD = AW'(ROM_WORDS - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [2:0]    count_q, count_d;
  logic [31:0]   instr_q [4];
  logic [31:0]   pc_q    [4];

  logic [AW-1:0] fetch_idx;
  logic          at_last_word;
  logic [1:0]    take_sat;
  logic [1:0]    take_eff;
  logic [1:0]    push_n;
  logic [1:0]    slot1;
  logic          unused_redirect_bits;

  assign fetch_idx    = fetch_pc_q[AW+1:2];
  assign at_last_word = (fetch_idx == LAST_WORD);
  assign imAddr       = {{(32-AW){1'b0}}, fetch_idx};

  // Only the word index of the redirect target is meaningful.
  assign unused_redirect_bits = &{1'b0, redirect_pc[31:AW+2], redirect_pc[1:0]};

  // A take of 3 is treated as 2, and never more than the queue holds.
  assign take_sat = (take == 2'd3) ? 2'd2 : take;
  assign take_eff = ({1'b0, take_sat} > count_q) ? count_q[1:0] : take_sat;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    push_n     = 2'd0;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q + take_eff;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q - 3'(take_eff);

    if (redirect) begin
      rd_ptr_d   = 2'd0;
      wr_ptr_d   = 2'd0;
      count_d    = 3'd0;
      fetch_pc_d = {{(30-AW){1'b0}}, redirect_pc[AW+1:2], 2'b00};
    end else if (count_q <= 3'd2) begin
      // The word after the last ROM word is not part of this fetch line.
      if (at_last_word) begin
        push_n     = 2'd1;
        fetch_pc_d = 32'h0000_0000;
      end else begin
        push_n     = 2'd2;
        fetch_pc_d = {{(30-AW){1'b0}}, fetch_idx + AW'(2), 2'b00};
      end
      wr_ptr_d = wr_ptr_q + push_n;
      count_d  = count_q - 3'(take_eff) + 3'(push_n);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates validity and
  // the outputs are zeroed for empty slots, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      instr_q[wr_ptr_q] <= imData1;
      pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
    if (push_n == 2'd2) begin
      instr_q[wr_ptr_q + 2'd1] <= imData2;
      pc_q[wr_ptr_q + 2'd1]    <= fetch_pc_q + 32'd4;
    end
  end

  assign slot1    = rd_ptr_q + 2'd1;
  assign i0_valid = (count_q != 3'd0);
  assign i1_valid = (count_q >= 3'd2);
  assign i0_instr = i0_valid ? instr_q[rd_ptr_q] : 32'h0;
  assign i0_pc    = i0_valid ? pc_q[rd_ptr_q]    : 32'h0;
  assign i1_instr = i1_valid ? instr_q[slot1]    : 32'h0;
  assign i1_pc    = i1_valid ? pc_q[slot1]       : 32'h0;

endmodule

// File: tb/tb_sm_fetch_pair.sv
// Directed bench for sm_fetch_pair; the ROM returns 32'h1000_0000 + word index.
module tb_sm_fetch_pair;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imAddr;
  logic [31:0] imData1;
  logic [31:0] imData2;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  take;
  logic        i0_valid;
  logic [31:0] i0_instr;
  logic [31:0] i0_pc;
  logic        i1_valid;
  logic [31:0] i1_instr;
  logic [31:0] i1_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imData1 = 32'h1000_0000 + {26'd0, imAddr[5:0]};
  assign imData2 = 32'h1000_0000 + {26'd0, imAddr[5:0] + 6'd1};

  sm_fetch_pair dut (
    .clk         (clk),
    .rst         (rst),
    .imAddr      (imAddr),
    .imData1     (imData1),
    .imData2     (imData2),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .take        (take),
    .i0_valid    (i0_valid),
    .i0_instr    (i0_instr),
    .i0_pc       (i0_pc),
    .i1_valid    (i1_valid),
    .i1_instr    (i1_instr),
    .i1_pc       (i1_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    take        = 2'd0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, then free-run consuming two per cycle (take=3 acts as 2).
    do_reset();
    check("rst_i0_valid", 32'(i0_valid), 32'd0);
    check("rst_i1_valid", 32'(i1_valid), 32'd0);
    check("rst_i0_pc",    i0_pc,    32'h0);
    check("rst_i0_instr", i0_instr, 32'h0);
    check("rst_i1_instr", i1_instr, 32'h0);
    check("rst_imaddr",   imAddr,   32'h0);
    take = 2'd2;
    step();
    check("c1_i0_valid", 32'(i0_valid), 32'd1);
    check("c1_i0_instr", i0_instr, 32'h1000_0000);
    check("c1_i0_pc",    i0_pc,    32'h0);
    check("c1_i1_instr", i1_instr, 32'h1000_0001);
    check("c1_i1_pc",    i1_pc,    32'h4);
    for (int k = 1; k <= 5; k++) begin
      take = (k % 2 == 1) ? 2'd3 : 2'd2;
      step();
      check("run_i0_pc",    i0_pc,    32'(8 * k));
      check("run_i1_pc",    i1_pc,    32'(8 * k + 4));
      check("run_i0_instr", i0_instr, 32'h1000_0000 + 32'(2 * k));
      check("run_i1_valid", 32'(i1_valid), 32'd1);
    end

    // Stall: queue fills to four and fetch freezes.
    do_reset();
    take = 2'd0;
    repeat (5) step();
    check("stall_imaddr",   imAddr,   32'd4);
    check("stall_i0_pc",    i0_pc,    32'h0);
    check("stall_i1_pc",    i1_pc,    32'h4);
    check("stall_i0_instr", i0_instr, 32'h1000_0000);
    check("stall_i1_valid", 32'(i1_valid), 32'd1);

    // Single take per cycle: head advances by one word with no bubbles.
    take = 2'd1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("take1_i0_valid", 32'(i0_valid), 32'd1);
      check("take1_i0_pc",    i0_pc,    32'(4 * i));
      check("take1_i1_pc",    i1_pc,    32'(4 * i + 4));
      check("take1_i0_instr", i0_instr, 32'h1000_0000 + 32'(i));
    end

    // Redirect with a full queue; low target bits ignored.
    take = 2'd0;
    repeat (3) step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0023;
    step();
    redirect = 1'b0;
    check("redir_n1_i0_valid", 32'(i0_valid), 32'd0);
    check("redir_n1_i1_valid", 32'(i1_valid), 32'd0);
    check("redir_n1_i0_pc",    i0_pc,  32'h0);
    check("redir_n1_imaddr",   imAddr, 32'd8);
    step();
    check("redir_n2_i0_pc",    i0_pc,    32'h20);
    check("redir_n2_i0_instr", i0_instr, 32'h1000_0008);
    check("redir_n2_i1_pc",    i1_pc,    32'h24);
    check("redir_n2_i1_valid", 32'(i1_valid), 32'd1);

    // Redirect to the last ROM word: single push, then wrap to word 0.
    take        = 2'd2;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_00FC;
    step();
    redirect = 1'b0;
    check("wrap_n1_i0_valid", 32'(i0_valid), 32'd0);
    check("wrap_n1_imaddr",   imAddr, 32'd63);
    step();
    check("wrap_n2_i0_valid", 32'(i0_valid), 32'd1);
    check("wrap_n2_i0_pc",    i0_pc,    32'hFC);
    check("wrap_n2_i0_instr", i0_instr, 32'h1000_003F);
    check("wrap_n2_i1_valid", 32'(i1_valid), 32'd0);
    check("wrap_n2_i1_pc",    i1_pc,    32'h0);
    check("wrap_n2_i1_instr", i1_instr, 32'h0);
    check("wrap_n2_imaddr",   imAddr,   32'd0);
    step();
    check("wrap_n3_i0_pc",    i0_pc,    32'h0);
    check("wrap_n3_i0_instr", i0_instr, 32'h1000_0000);
    check("wrap_n3_i1_pc",    i1_pc,    32'h4);
    check("wrap_n3_i1_valid", 32'(i1_valid), 32'd1);

    // Reset mid-stream overrides a simultaneous redirect.
    repeat (2) step();
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    check("mrst_i0_valid", 32'(i0_valid), 32'd0);
    check("mrst_i1_valid", 32'(i1_valid), 32'd0);
    check("mrst_imaddr",   imAddr, 32'd0);
    rst      = 1'b0;
    redirect = 1'b0;
    step();
    check("mrst_c1_i0_valid", 32'(i0_valid), 32'd1);
    check("mrst_c1_i0_pc",    i0_pc,    32'h0);
    check("mrst_c1_i0_instr", i0_instr, 32'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
